hue_div_sched: RTL
==================

# hue_div_sched

Round-robin scheduler that shares one pipelined hue divider (`hue_stage0`, fixed latency `DIVIDE_LATENCY`) between `NUM_REQ` requesters in the color-detect pipeline, e.g. hue and saturation stages.

- Grants at most one request per cycle and registers it onto the divider inputs.
- Tracks each in-flight operation's owner in a tag pipeline matched to the divider latency.
- Routes each divider result back to the requester that issued it and flags any tag/valid misalignment.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters, 2–4.
- `DIVIDE_LATENCY`, 16, divider cycles from `o_div_valid` to `i_div_valid`.
- `TAG_W`, `$clog2(NUM_REQ)` (minimum 1), owner-tag width. Derived; do not override.

Ports:
- `i_clk`  in  1  — sole clock; all logic on the rising edge.
- `i_rstn`  in  1  — asynchronous, active-low reset.
- `i_req_valid`  in  `NUM_REQ`  — per-requester request valid.
- `o_req_ready`  out  `NUM_REQ`  — per-requester grant (combinational).
- `i_req_dividend`  in  `NUM_REQ*9`  — packed; slice `i*9 +: 9`.
- `i_req_divisor`  in  `NUM_REQ*9`  — packed; slice `i*9 +: 9`.
- `i_req_function`  in  `NUM_REQ*2`  — packed; slice `i*2 +: 2`.
- `o_div_dividend`  out  9  — to divider.
- `o_div_divisor`  out  9  — to divider.
- `o_div_function`  out  2  — to divider.
- `o_div_valid`  out  1  — to divider.
- `i_div_data`  in  16  — divider result.
- `i_div_valid`  in  1  — divider result valid.
- `o_res_data`  out  `NUM_REQ*16`  — per-requester result; slice `i*16 +: 16`.
- `o_res_valid`  out  `NUM_REQ`  — per-requester result strobe.
- `o_idle`  out  1  — high when no operation is in flight and no issue is pending.
- `o_err`  out  1  — sticky misalignment flag.

## Operation
- Arbitration: round-robin. `last_grant` resets to `NUM_REQ-1`, so requester 0 wins first.
  - Search order is `last_grant+1` upward, wrapping modulo `NUM_REQ`.
  - `o_req_ready[i]` is high for exactly the winning valid requester and zero elsewhere; it is all-zero when no request is valid.
  - A handshake is `valid & ready`. `last_grant` updates only on a handshake.
  - A requester holding `valid` with no competition is granted every cycle.
- Issue: on a handshake, the winner's operands and function are registered onto the `o_div_*` ports with `o_div_valid=1`. Otherwise `o_div_valid=0` and the operands are zero.
  - The function code is passed through unchanged; legal values are 1–3 and the block performs no checking.
  - A divisor of 0 is issued as-is. The divider owns divide-by-zero handling.
- Tag pipeline: `DIVIDE_LATENCY` stages, each holding `{valid, tag}`. The stage-0 input is `{o_div_valid, owner of the registered op}`.
  - On `i_div_valid & tail.valid`: `o_res_valid[tail.tag]` is strobed for one cycle and `i_div_data` is copied to that requester's slice.
  - The other slices hold their last value.
- Error: `o_err` is set and held until reset when the tag-pipeline tail and `i_div_valid` disagree.
  - `i_div_valid` without `tail.valid`: the result is dropped.
  - `tail.valid` without `i_div_valid`: the operation is lost and no strobe is produced.
- In-flight counter: 0 to `DIVIDE_LATENCY+1`. It increments on a handshake and decrements on a tail retire (valid or lost); both in one cycle leaves it unchanged. `o_idle` = (count==0).

## Timing
- Reset values: `o_div_*`=0, `o_res_data`=0, `o_res_valid`=0, `o_err`=0, `o_idle`=1, tag pipeline cleared, `last_grant=NUM_REQ-1`.
  - `o_req_ready` follows `i_req_valid` combinationally but is forced to 0 while `i_rstn=0`.
- Latency: a handshake in cycle N gives `o_div_valid` in N+1 and `o_res_valid` in N+1+`DIVIDE_LATENCY`; total `DIVIDE_LATENCY+1`.
- Throughput: one operation per cycle, aggregate across requesters; there is no backpressure on results.
- Simultaneous events: issue and retire in the same cycle are independent. The counter rule above applies.
- Reset mid-operation: all in-flight tags are discarded and no result strobes occur afterwards. The divider shares `i_rstn`, so no stale `i_div_valid` is expected; if one arrives, `o_err` is set.

## Structure
- Shared package `color_detect_pkg`:
  - `DIV_OPERAND_W`=9, `DIV_RESULT_W`=16, `DIV_FUNC_W`=2.
  - typedef `div_tag_t` (`{logic valid; logic [TAG_W-1:0] tag;}`) as a parameterized struct pattern.
- One sub-module, `rr_arbiter` (parameter `N`): inputs `req` and `advance`, output one-hot `grant`. It holds the `last_grant` pointer and is reusable elsewhere in the pipeline.
- The tag pipeline, routing and counter stay inline in `hue_div_sched`.

## Test plan
Benches run `hue_div_sched` with `hue_stage0` (`DIVIDE_LATENCY`=16) attached as the divider unless a case says otherwise.
- Single request: requester 0 issues (-5, 2, func 1) in cycle N → `o_div_valid` at N+1; `o_res_valid` = 2'b01 at N+17 with the `hue_stage0` result; `o_idle` returns to 1 at N+18.
- Contention: both requesters hold valid for 6 cycles → grants alternate 0,1,0,1,0,1. Results return in that order, 17 cycles after each grant, with no drops.
- Back-to-back from one requester: requester 1 issues (1,3), (0,3), (25,0), (-42,0), (3,2) on consecutive cycles → five consecutive `o_res_valid[1]` strobes in order; `o_err` stays 0.
- Reset mid-flight: assert `i_rstn`=0 eight cycles after issuing (-10, 3) → no result strobe follows; after release `o_idle`=1, `o_err`=0, and requester 0 is granted first.
- Misalignment: replace the divider with a stub that injects `i_div_valid` with the pipeline empty → data dropped, `o_err`=1 and held until reset.
- Idle-gap wrap: requester 1 is granted, 20 idle cycles pass, then both request → requester 0 wins (pointer wraps), then requester 1.

Source files
------------

// File: rtl/color_detect_pkg.sv
// rtl/color_detect_pkg.sv - shared widths and tag type for the color-detect divider path
package color_detect_pkg;

  localparam int DIV_OPERAND_W = 9;
  localparam int DIV_RESULT_W  = 16;
  localparam int DIV_FUNC_W    = 2;

  // Widest owner tag needed for up to four requesters; narrower owners are zero-extended.
  localparam int DIV_TAG_MAX_W = 2;

  typedef struct packed {
    logic                     valid;
    logic [DIV_TAG_MAX_W-1:0] tag;
  } div_tag_t;

  // Owner-tag width for n requesters, never below one bit.
  function automatic int tag_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant and last-grant pointer
module rr_arbiter
  import color_detect_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PTR_W = tag_width(N);

  logic [PTR_W-1:0] last_grant;
  logic [PTR_W-1:0] grant_idx;

  // Search from last_grant+1 upward, wrapping, and pick the first valid request.
  always_comb begin
    int         idx;
    logic       found;
    logic [PTR_W-1:0] sel;
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      sel = PTR_W'(idx);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        grant_idx  = sel;
        found      = 1'b1;
      end
    end
  end

  // Pointer moves only when the granted request is actually taken.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      last_grant <= PTR_W'(N - 1);
    end else if (advance) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/hue_div_sched.sv
// rtl/hue_div_sched.sv - shares one pipelined hue divider between several requesters
module hue_div_sched
  import color_detect_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DIVIDE_LATENCY = 16,
  parameter int TAG_W          = tag_width(NUM_REQ)
) (
  input  logic                              i_clk,
  input  logic                              i_rstn,
  input  logic [NUM_REQ-1:0]                i_req_valid,
  output logic [NUM_REQ-1:0]                o_req_ready,
  input  logic [NUM_REQ*DIV_OPERAND_W-1:0]  i_req_dividend,
  input  logic [NUM_REQ*DIV_OPERAND_W-1:0]  i_req_divisor,
  input  logic [NUM_REQ*DIV_FUNC_W-1:0]     i_req_function,
  output logic [DIV_OPERAND_W-1:0]          o_div_dividend,
  output logic [DIV_OPERAND_W-1:0]          o_div_divisor,
  output logic [DIV_FUNC_W-1:0]             o_div_function,
  output logic                              o_div_valid,
  input  logic [DIV_RESULT_W-1:0]           i_div_data,
  input  logic                              i_div_valid,
  output logic [NUM_REQ*DIV_RESULT_W-1:0]   o_res_data,
  output logic [NUM_REQ-1:0]                o_res_valid,
  output logic                              o_idle,
  output logic                              o_err
);

  localparam int CNT_W = $clog2(DIVIDE_LATENCY + 2);

  logic [NUM_REQ-1:0]              grant;
  logic [NUM_REQ-1:0]              handshake;
  logic                            issue;
  logic [TAG_W-1:0]                owner;
  logic [TAG_W-1:0]                issue_tag;
  div_tag_t                        tag_pipe [DIVIDE_LATENCY];
  div_tag_t                        tail;
  logic                            retire_ok;
  logic [NUM_REQ*DIV_RESULT_W-1:0] res_hold;
  logic [CNT_W-1:0]                inflight;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .req     (i_req_valid),
    .advance (issue),
    .grant   (grant)
  );

  // Grants never leak out while the block is held in reset.
  assign o_req_ready = grant & {NUM_REQ{i_rstn}};
  assign handshake   = i_req_valid & o_req_ready;
  assign issue       = |handshake;

  // Encode the one-hot winner into an owner index.
  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (handshake[i]) owner = TAG_W'(i);
    end
  end

  // Register the winning operands onto the divider; zero the bus when nothing issues.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_div_valid    <= 1'b0;
      o_div_dividend <= '0;
      o_div_divisor  <= '0;
      o_div_function <= '0;
      issue_tag      <= '0;
    end else begin
      o_div_valid <= issue;
      issue_tag   <= issue ? owner : '0;
      if (issue) begin
        o_div_dividend <= i_req_dividend[int'(owner)*DIV_OPERAND_W +: DIV_OPERAND_W];
        o_div_divisor  <= i_req_divisor[int'(owner)*DIV_OPERAND_W +: DIV_OPERAND_W];
        o_div_function <= i_req_function[int'(owner)*DIV_FUNC_W +: DIV_FUNC_W];
      end else begin
        o_div_dividend <= '0;
        o_div_divisor  <= '0;
        o_div_function <= '0;
      end
    end
  end

  // Owner tags travel alongside the divider so the tail lines up with i_div_valid.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int k = 0; k < DIVIDE_LATENCY; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: o_div_valid, tag: DIV_TAG_MAX_W'(issue_tag)};
      for (int k = 1; k < DIVIDE_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign tail      = tag_pipe[DIVIDE_LATENCY-1];
  assign retire_ok = i_div_valid & tail.valid;

  // Steer the strobe to the owner and bypass the fresh result onto its slice.
  always_comb begin
    o_res_valid = '0;
    o_res_data  = res_hold;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (retire_ok && (tail.tag == DIV_TAG_MAX_W'(i))) begin
        o_res_valid[i]                               = 1'b1;
        o_res_data[i*DIV_RESULT_W +: DIV_RESULT_W]   = i_div_data;
      end
    end
  end

  // Each slice keeps the last result delivered to that requester.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      res_hold <= '0;
    end else begin
      res_hold <= o_res_data;
    end
  end

  // Sticky flag whenever the divider's valid disagrees with the expected tail.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_err <= 1'b0;
    end else if (i_div_valid != tail.valid) begin
      o_err <= 1'b1;
    end
  end

  // Count operations between issue and tail retirement, delivered or lost.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      inflight <= '0;
    end else begin
      case ({issue, tail.valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign o_idle = (inflight == '0);

endmodule
